// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU byte/half/word requests into word-aligned memory
// accesses with byte enables, splitting any access that straddles a word boundary.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE0, S_WAIT0, S_ISSUE1, S_WAIT1, S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  active_q;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;

    logic [1:0]              off;
    logic [3:0]              mask4;
    logic [7:0]              m8;
    logic                    split;
    logic [DATA_WIDTH-1:0]   wmask;
    logic [2*DATA_WIDTH-1:0] wide;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rd_ext;
    logic [ADDR_WIDTH-1:0]   base_addr;

    assign off       = addr_q[1:0];
    assign base_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        case (size_q)
            2'b00:   begin mask4 = 4'b0001; wmask = 32'h0000_00FF; end
            2'b01:   begin mask4 = 4'b0011; wmask = 32'h0000_FFFF; end
            default: begin mask4 = 4'b1111; wmask = 32'hFFFF_FFFF; end
        endcase
    end

    assign m8    = {4'b0000, mask4} << off;
    assign split = |m8[7:4];

    // Store data is masked to its size first so lanes outside mem_be are always 0;
    // the upper half of the shifted value is the second-word payload.
    assign wide = {{DATA_WIDTH{1'b0}}, wdata_q & wmask} << {off, 3'b000};

    assign rd_word = DATA_WIDTH'({hi_q, lo_q} >> {off, 3'b000});

    always_comb begin
        case (size_q)
            2'b00:   rd_ext = uns_q ? {24'd0, rd_word[7:0]}  : {{24{rd_word[7]}}, rd_word[7:0]};
            2'b01:   rd_ext = uns_q ? {16'd0, rd_word[15:0]} : {{16{rd_word[15]}}, rd_word[15:0]};
            default: rd_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            active_q <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = 4'b0000;
        mem_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                // Not ready until the first clock edge after reset release.
                req_ready = active_q;
                if (req_valid && active_q) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    lo_d    = '0;
                    hi_d    = '0;
                    err_d   = (req_size == 2'b11);
                    state_d = (req_size == 2'b11) ? S_RESP : S_ISSUE0;
                end
            end
            S_ISSUE0: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = base_addr;
                mem_be    = m8[3:0];
                mem_wdata = wide[DATA_WIDTH-1:0];
                if (mem_gnt) begin
                    if (!we_q)     state_d = S_WAIT0;
                    else if (split) state_d = S_ISSUE1;
                    else            state_d = S_RESP;
                end
            end
            S_WAIT0: begin
                if (mem_rvalid) begin
                    lo_d    = mem_rdata;
                    state_d = split ? S_ISSUE1 : S_RESP;
                end
            end
            S_ISSUE1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = base_addr + ADDR_WIDTH'(4);
                mem_be    = m8[7:4];
                mem_wdata = wide[2*DATA_WIDTH-1:DATA_WIDTH];
                if (mem_gnt) begin
                    state_d = we_q ? S_RESP : S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (mem_rvalid) begin
                    hi_d    = mem_rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (we_q || err_q) ? '0 : rd_ext;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for the byte-addressed data memory port. Converts pipeline load/store requests into word-aligned memory accesses with byte enables.
- Sizes: byte, halfword, word. Loads are sign- or zero-extended.
- An access that crosses a 4-byte boundary is split into two back-to-back aligned accesses.
- Sits between the execute/memory stage and the data memory.

Parameters:
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend load (LBU/LHU).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  extended load result; 0 for stores.
- resp_err  out  1  qualifies resp_valid; set for illegal size.
- mem_req  out  1  memory access request.
- mem_gnt  in  1  memory accepts the access this cycle.
- mem_we  out  1  write access.
- mem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
- mem_be  out  4  byte lane enables.
- mem_wdata  out  DATA_WIDTH  lane-aligned write data.
- mem_rvalid  in  1  read data valid (1 or more cycles after grant).
- mem_rdata  in  DATA_WIDTH  read word.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal buffers cleared. req_ready becomes 1 the first cycle after rst_n deasserts.
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* fields.
  - Compute off = addr[1:0] and mask = 0001, 0011 or 1111 (by size), then m8 = mask << off (8 bits).
  - split = (m8[7:4] != 0).
  - Size 11: go to RESP with resp_err=1; no memory access.
  - Otherwise go to ISSUE0.
- req_ready=0 in every state except IDLE. req_valid is ignored while busy.
- ISSUE0:
  - mem_req=1, mem_addr = {addr[31:2],00}, mem_be = m8[3:0], mem_wdata = wdata << 8*off, mem_we = req_we.
  - All of these hold stable until mem_gnt.
  - On gnt: a load goes to WAIT0; a store goes to ISSUE1 if split, else RESP.
- WAIT0: mem_req=0. On mem_rvalid, capture lo = mem_rdata, then go to ISSUE1 if split, else RESP.
- ISSUE1:
  - mem_addr = first address + 4 (wraps modulo 2^ADDR_WIDTH, so 0xFFFFFFFC → 0x00000000).
  - mem_be = m8[7:4], mem_wdata = wdata >> 8*(4-off).
  - On gnt: a load goes to WAIT1; a store goes to RESP.
- WAIT1: on mem_rvalid capture hi, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - Load result: take {hi,lo} >> 8*off, truncate to size, then extend. Sign bit is bit 7 (byte) or bit 15 (half); zero-extend if req_unsigned. Word loads ignore req_unsigned.
  - Unused hi reads as 0 when not split.
- Latency with gnt in the request cycle and rvalid 1 cycle after grant:
  - Aligned load: resp_valid 3 cycles after acceptance.
  - Aligned store: 2 cycles.
  - Split load: 5 cycles.
  - Split store: 3 cycles.
- mem_rvalid outside WAIT0/WAIT1 is ignored.
- mem_gnt while mem_req=0 is ignored.
- mem_req is never asserted in IDLE, WAIT*, or RESP.
- Bytes outside mem_be are don't-care on mem_wdata but must be driven 0.
- There is no back-pressure on resp_valid.
- rst_n assertion mid-transaction: immediate return to IDLE, mem_req and resp_valid drop asynchronously, and the transaction is discarded with no response.

Test Plan:
- Aligned load, mem word at 0x100 = 0xDEADBEEF: LW 0x100 → mem_addr 0x100, be 1111; resp_rdata 0xDEADBEEF, resp_valid 3 cycles after accept.
- Byte loads, mem word at 0x100 = 0x80000000:
  - LB 0x103 → be 1000, resp_rdata 0xFFFFFF80.
  - LBU 0x103 → 0x00000080.
  - LH 0x102 → 0xFFFF8000.
- Split store: SW 0x11223344 to 0x102 → access 1 addr 0x100, be 1100, wdata 0x33440000; access 2 addr 0x104, be 0011, wdata 0x00001122; one resp_valid.
- Split load with wrap, mem[0xFFFFFFFC] = 0xAB000000, mem[0x0] = 0x000000CD: LHU 0xFFFFFFFF → second addr 0x00000000, resp_rdata 0x0000CDAB.
- Stall and illegal size:
  - mem_gnt held low 4 cycles on SB 0x5A to 0x201 → mem_addr/be (0010)/wdata (0x00005A00) stable throughout; single write.
  - req_size=11 → resp_valid with resp_err=1, mem_req never asserted.
- Reset mid-op: assert rst_n low in WAIT0 of a load, then deliver mem_rvalid after release → no resp_valid, req_ready=1; the next LW completes normally.
